clock_gate_ctrl: RTL
====================

# clock_gate_ctrl

Clock-gate enable controller: a small per-channel state machine that opens a downstream clock gate on demand and closes it after a programmable idle interval. Sits directly upstream of the triplicated clock-gating cell and drives its `clkGate` vector, one bit per gated domain. Written as plain single-copy RTL; TMR triplication and the voter on `clkGate` are added downstream.

## Interface
- `NCH`, 3: number of gated channels, which is the width of `clkGate`.
- `IDLE_CYCLES`, 16: consecutive idle cycles in ON before the gate closes; legal range 1..255.
- `WAKE_CYCLES`, 2: cycles between gate opening and `ready`; legal range 1..255.

Ports:
- `clk` input 1: single clock. All logic is on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `enable` input NCH: per-channel permission to wake.
- `force_on` input NCH: override. Keeps the gate open and overrides both `enable` and the idle timeout.
- `wake_req` input NCH: level wake request, held by the requester until `ready`.
- `activity` input NCH: channel busy indication. Restarts the idle timer.
- `clkGate` output NCH: gate enable to the clock-gating cell. Registered.
- `ready` output NCH: gated clock is stable and usable. Registered.

## Operation
Each channel is independent and has its own FSM with four states: OFF, WAKE, ON, DRAIN.

Definitions:
- `wake` = `force_on | (enable & (wake_req | activity))`
- `idle` = `!force_on & !wake_req & !activity`

State outputs:
- OFF: `clkGate`=0, `ready`=0. If `wake` → WAKE and load `wcnt`=WAKE_CYCLES-1.
- WAKE: `clkGate`=1, `ready`=0.
  - If `!enable & !force_on` → OFF.
  - Else if `wcnt`==0 → ON and clear `icnt`.
  - Else decrement `wcnt`.
- ON: `clkGate`=1, `ready`=1.
  - If `!enable & !force_on` → DRAIN.
  - Else if `idle`: when `icnt`==IDLE_CYCLES-1 → DRAIN, otherwise increment `icnt`.
  - Else (not `idle`) clear `icnt`.
- DRAIN: `clkGate`=1, `ready`=0, for one cycle, then unconditionally → OFF. A `wake_req` seen in DRAIN is re-evaluated in OFF because it is a held level.

Rules:
- `force_on` has priority over every exit condition.
- `clkGate` never drops while `ready`=1. `ready` always falls at least one cycle before `clkGate`.
- `wcnt` and `icnt` are 8 bits each, saturating, never wrap.
- Reset mid-operation returns every channel to OFF in the next cycle regardless of state. There is no DRAIN on reset.

## Timing
Reset values:
- All outputs 0.
- State OFF.
- `wcnt` and `icnt` 0.

Wake latency, for `wake` first sampled high in OFF at cycle n:
- `clkGate`=1 at n+1.
- `ready`=1 at n+1+WAKE_CYCLES.

Idle close, for the last non-idle cycle n in ON:
- `ready`=0 at n+IDLE_CYCLES+1.
- `clkGate`=0 at n+IDLE_CYCLES+2.

Enable close:
- `enable` falling in ON at cycle n gives `ready`=0 at n+1 and `clkGate`=0 at n+2.
- `enable` falling in WAKE at cycle n gives `clkGate`=0 at n+1.

Other timing rules:
- Activity on the exact cycle `icnt` reaches IDLE_CYCLES-1 keeps the channel in ON and clears `icnt`.
- There is no combinational path from inputs to outputs.

## Structure
Shared package `clock_gate_pkg`:
- State enum: OFF=2'b00, WAKE=2'b01, ON=2'b10, DRAIN=2'b11.
- `CNT_W`=8.
- Default IDLE/WAKE constants.

Sub-modules:
- `clock_gate_chan` holds one channel FSM and its two counters.
- `clock_gate_ctrl` instantiates `clock_gate_chan` NCH times with a generate loop and concatenates the outputs.

## Test plan
- **Reset:** hold `rst`=1 for 3 cycles with all inputs high → `clkGate`=000, `ready`=000 during reset. The first post-reset cycle is still 000. `clkGate`=111 one cycle later, because the inputs force wake.
- **Wake:** WAKE_CYCLES=2, `enable[0]`=1, `wake_req[0]` rises at cycle 10 → `clkGate[0]`=1 at 11, `ready[0]`=1 at 13. Channels 1 and 2 stay 0.
- **Idle close:** IDLE_CYCLES=16, channel 0 in ON, last `activity` at cycle 20 → `ready[0]`=0 at 37, `clkGate[0]`=0 at 38.
- **Timer restart:** `activity` pulses every 15 cycles with IDLE_CYCLES=16 → the gate never closes over 200 cycles.
- **Force and enable:** `force_on[1]`=1 with `enable[1]`=0 → gate opens and stays open indefinitely. Dropping `force_on` in ON at cycle 50 → `ready[1]`=0 at 51, `clkGate[1]`=0 at 52.
- **Reset mid-operation:** assert `rst` while channel 2 is in WAKE → next cycle `clkGate[2]`=0 with no `ready` pulse. Re-raising `wake_req` after reset gives the normal wake latency.

Source files
------------

// File: rtl/clock_gate_pkg.sv
// clock_gate_pkg: shared state encoding, counter width and default timing for the clock-gate controller
package clock_gate_pkg;
    typedef enum logic [1:0] {
        OFF   = 2'b00,
        WAKE  = 2'b01,
        ON    = 2'b10,
        DRAIN = 2'b11
    } state_t;
    localparam int CNT_W = 8;
    localparam int DEF_IDLE_CYCLES = 16;
    localparam int DEF_WAKE_CYCLES = 2;
endpackage

// File: rtl/clock_gate_chan.sv
// clock_gate_chan: one channel's gate FSM with wake-delay and idle-timeout counters
module clock_gate_chan
    import clock_gate_pkg::*;
#(
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic force_on,
    input  logic wake_req,
    input  logic activity,
    output logic gate,
    output logic ready
);
    localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 1);
    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);
    state_t state;
    logic [CNT_W-1:0] wcnt;
    logic [CNT_W-1:0] icnt;
    logic wake;
    logic idle;
    logic keep;
    assign wake = force_on | (enable & (wake_req | activity));
    assign idle = ~force_on & ~wake_req & ~activity;
    assign keep = enable | force_on;
    // ready is cleared on every exit from ON, so it always falls a cycle before gate
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= OFF;
            wcnt  <= '0;
            icnt  <= '0;
            gate  <= 1'b0;
            ready <= 1'b0;
        end else begin
            case (state)
                OFF: if (wake) begin
                    state <= WAKE;
                    wcnt  <= WAKE_LOAD;
                    gate  <= 1'b1;
                end
                WAKE: if (!keep) begin
                    state <= OFF;
                    gate  <= 1'b0;
                end else if (wcnt == '0) begin
                    state <= ON;
                    icnt  <= '0;
                    ready <= 1'b1;
                end else begin
                    wcnt <= wcnt - 1'b1;
                end
                ON: if (!keep || (idle && icnt == IDLE_LAST)) begin
                    state <= DRAIN;
                    ready <= 1'b0;
                end else if (idle) begin
                    icnt <= (icnt == '1) ? icnt : icnt + 1'b1;
                end else begin
                    icnt <= '0;
                end
                DRAIN: begin
                    state <= OFF;
                    gate  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: rtl/clock_gate_ctrl.sv
// clock_gate_ctrl: NCH independent clock-gate enable channels feeding the gating cell
module clock_gate_ctrl
    import clock_gate_pkg::*;
#(
    parameter int NCH         = 3,
    parameter int IDLE_CYCLES = DEF_IDLE_CYCLES,
    parameter int WAKE_CYCLES = DEF_WAKE_CYCLES
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] enable,
    input  logic [NCH-1:0] force_on,
    input  logic [NCH-1:0] wake_req,
    input  logic [NCH-1:0] activity,
    output logic [NCH-1:0] clkGate,
    output logic [NCH-1:0] ready
);
    for (genvar i = 0; i < NCH; i++) begin : g_chan
        clock_gate_chan #(
            .IDLE_CYCLES(IDLE_CYCLES),
            .WAKE_CYCLES(WAKE_CYCLES)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .enable  (enable[i]),
            .force_on(force_on[i]),
            .wake_req(wake_req[i]),
            .activity(activity[i]),
            .gate    (clkGate[i]),
            .ready   (ready[i])
        );
    end
endmodule
